// File: rtl/qea_pkg.sv
// Shared types and helpers for the QEA state-RAM access blocks: amplitude
// slicing, lane extraction from a packed row and the reader FSM encoding.
package qea_pkg;

    localparam int QEA_PE_NUM_WIDTH     = 2;
    localparam int QEA_PE_NUM           = 1 << QEA_PE_NUM_WIDTH;
    localparam int QEA_DATA_WIDTH       = 32;
    localparam int QEA_STATE_DATA_WIDTH = 2 * QEA_DATA_WIDTH;
    localparam int QEA_STATE_ADDR_WIDTH = 16;
    localparam int QEA_MAX_QBIT_WIDTH   = 6;
    localparam int QEA_NUM_FRAC_BIT     = 30;
    localparam int QEA_RAM_RD_LATENCY   = 2;
    localparam int QEA_LAT_CTR_WIDTH    = 3;
    localparam int QEA_ROW_WIDTH        = QEA_PE_NUM * QEA_STATE_DATA_WIDTH;

    typedef logic [QEA_STATE_DATA_WIDTH-1:0] qea_amp_t;
    typedef logic signed [QEA_DATA_WIDTH-1:0] qea_part_t;
    typedef logic [QEA_ROW_WIDTH-1:0]        qea_row_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SEND,
        DONE
    } qea_rd_state_e;

    function automatic qea_part_t amp_re(input qea_amp_t amp);
        return amp[QEA_STATE_DATA_WIDTH-1 -: QEA_DATA_WIDTH];
    endfunction

    function automatic qea_part_t amp_im(input qea_amp_t amp);
        return amp[QEA_DATA_WIDTH-1:0];
    endfunction

    // Lane 0 sits in the most significant slice of the row.
    function automatic qea_amp_t lane_extract(input qea_row_t row_buf,
                                              input logic [QEA_PE_NUM_WIDTH-1:0] lane);
        return qea_amp_t'(row_buf >> ((QEA_PE_NUM - 1 - int'(lane)) * QEA_STATE_DATA_WIDTH));
    endfunction

    function automatic logic [QEA_STATE_ADDR_WIDTH:0] rows_last(
        input logic [QEA_MAX_QBIT_WIDTH-1:0] qbit_num);
        logic [QEA_STATE_ADDR_WIDTH:0] one;
        one = 1;
        if (qbit_num > QEA_MAX_QBIT_WIDTH'(QEA_PE_NUM_WIDTH))
            return (one << (qbit_num - QEA_MAX_QBIT_WIDTH'(QEA_PE_NUM_WIDTH))) - one;
        return '0;
    endfunction

endpackage

// File: rtl/qea_rd_lat_ctr.sv
// Read-latency countdown: load a cycle count, o_expire flags the final
// cycle of the wait. Shared by the state reader and the write-side loader.
module qea_rd_lat_ctr
    import qea_pkg::*;
#(
    parameter int WIDTH = QEA_LAT_CTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_expire
);

    logic [WIDTH-1:0] count;
    logic             running;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            running <= 1'b0;
        end else if (i_load) begin
            count   <= i_load_val;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0)
                running <= 1'b0;
            else
                count <= count - 1'b1;
        end
    end

    assign o_expire = running && (count == '0);

endmodule

// File: rtl/qea_state_reader.sv
// Drains the QEA state RAM row by row and streams one amplitude per beat.
// Define QEA_RD_PROB_EN to drive o_m_prob with |amp|^2; otherwise it is 0.
module qea_state_reader
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH     = QEA_PE_NUM_WIDTH,
    parameter int PE_NUM           = QEA_PE_NUM,
    parameter int DATA_WIDTH       = QEA_DATA_WIDTH,
    parameter int STATE_DATA_WIDTH = QEA_STATE_DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH = QEA_STATE_ADDR_WIDTH,
    parameter int MAX_QBIT_WIDTH   = QEA_MAX_QBIT_WIDTH,
    parameter int NUM_FRAC_BIT     = QEA_NUM_FRAC_BIT,
    parameter int RAM_RD_LATENCY   = QEA_RAM_RD_LATENCY
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
    input  logic                                     i_complete,
    input  logic                                     i_rd_start,
    output logic [PE_NUM-1:0]                        o_state_ena,
    output logic [PE_NUM-1:0]                        o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
    output logic                                     o_m_valid,
    input  logic                                     i_m_ready,
    output logic [STATE_DATA_WIDTH-1:0]              o_m_data,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_m_index,
    output logic                                     o_m_last,
    output logic [DATA_WIDTH-1:0]                    o_m_prob,
    output logic                                     o_busy,
    output logic                                     o_done,
    output logic                                     o_err
);

    qea_rd_state_e                   state, state_nxt;
    logic                            complete_q;
    logic                            trigger;
    logic                            qbit_ok;
    logic                            lat_expire;
    logic                            handshake;
    logic                            lane_end;
    logic                            row_end;
    logic [STATE_ADDR_WIDTH:0]       row;
    logic [STATE_ADDR_WIDTH:0]       row_last;
    logic [PE_NUM_WIDTH-1:0]         lane;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0] row_buf;
    logic                            err;
    qea_amp_t                        cur_amp;

    assign trigger   = (i_complete & ~complete_q) | i_rd_start;
    assign qbit_ok   = i_qbit_num <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    assign handshake = (state == SEND) && i_m_ready;
    assign lane_end  = lane == PE_NUM_WIDTH'(PE_NUM - 1);
    assign row_end   = row == row_last;

    qea_rd_lat_ctr #(
        .WIDTH(QEA_LAT_CTR_WIDTH)
    ) u_lat_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (state == ISSUE),
        .i_load_val(QEA_LAT_CTR_WIDTH'(RAM_RD_LATENCY - 1)),
        .o_expire  (lat_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (trigger && qbit_ok) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (lat_expire) state_nxt = SEND;
            SEND:    if (handshake && lane_end) state_nxt = row_end ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Triggers outside IDLE are dropped; complete_q keeps tracking the level
    // so an edge seen mid-sweep cannot start a second sweep afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            complete_q <= 1'b0;
            row        <= '0;
            row_last   <= '0;
            lane       <= '0;
            row_buf    <= '0;
            err        <= 1'b0;
        end else begin
            complete_q <= i_complete;
            if (state == IDLE && trigger) begin
                if (qbit_ok) begin
                    row      <= '0;
                    lane     <= '0;
                    row_last <= rows_last(i_qbit_num);
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == WAIT && lat_expire)
                row_buf <= i_state_dout;
            if (handshake) begin
                lane <= lane + 1'b1;
                if (lane_end && !row_end)
                    row <= row + 1'b1;
            end
        end
    end

    assign cur_amp       = lane_extract(row_buf, lane);
    assign o_state_ena   = (state == ISSUE) ? {PE_NUM{1'b1}} : '0;
    assign o_state_wea   = '0;
    assign o_state_addra = row[STATE_ADDR_WIDTH-1:0];
    assign o_m_valid     = (state == SEND);
    assign o_m_data      = cur_amp;
    assign o_m_index     = {row[STATE_ADDR_WIDTH-1:0], lane};
    assign o_m_last      = (state == SEND) && lane_end && row_end;
    assign o_busy        = (state == ISSUE) || (state == WAIT) || (state == SEND);
    assign o_done        = (state == DONE);
    assign o_err         = err;

`ifdef QEA_RD_PROB_EN
    localparam int SCALED_W = 2 * DATA_WIDTH - NUM_FRAC_BIT + 1;

    logic signed [2*DATA_WIDTH-1:0] re_ext, im_ext;
    logic signed [2*DATA_WIDTH-1:0] re_sq, im_sq;
    logic [2*DATA_WIDTH:0]          mag_sum;
    logic [SCALED_W-1:0]            mag_scaled;

    // Squares are non-negative, so the sum is treated as unsigned and
    // clamped to all ones when it overflows the output width.
    assign re_ext     = (2*DATA_WIDTH)'(amp_re(cur_amp));
    assign im_ext     = (2*DATA_WIDTH)'(amp_im(cur_amp));
    assign re_sq      = re_ext * re_ext;
    assign im_sq      = im_ext * im_ext;
    assign mag_sum    = {1'b0, re_sq} + {1'b0, im_sq};
    assign mag_scaled = SCALED_W'(mag_sum >> NUM_FRAC_BIT);
    assign o_m_prob   = (|mag_scaled[SCALED_W-1:DATA_WIDTH]) ? '1 : mag_scaled[DATA_WIDTH-1:0];
`else
    assign o_m_prob   = '0;
`endif

endmodule

// File: tb/tb_qea_state_reader.sv
// Scoreboard bench for qea_state_reader: expected beats are queued at
// stimulus time and popped by a monitor on every stream handshake.
`timescale 1ns/1ps
module tb_qea_state_reader;
    import qea_pkg::*;

    localparam int PAT_BASIC = 0;
    localparam int PAT_K     = 1;
`ifdef QEA_RD_PROB_EN
    localparam logic [31:0] PROB_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] PROB_MASK = 32'h0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [17:0] index;
        logic        last;
        logic [31:0] prob;
        int          prob_tol;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [5:0]   i_qbit_num;
    logic         i_complete;
    logic         i_rd_start;
    logic [3:0]   o_state_ena;
    logic [3:0]   o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] i_state_dout;
    logic         o_m_valid;
    logic         i_m_ready = 1'b0;
    logic [63:0]  o_m_data;
    logic [17:0]  o_m_index;
    logic         o_m_last;
    logic [31:0]  o_m_prob;
    logic         o_busy;
    logic         o_done;
    logic         o_err;

    beat_t        exp_q[$];
    logic [255:0] mem [0:127];
    logic [255:0] rd_stage1 = '0;
    logic [255:0] rd_stage2 = '0;

    int num_checks = 0;
    int num_failures = 0;
    int beats_seen = 0;
    int done_count = 0;
    int issue_count = 0;
    int busy_seen = 0;
    int addr_out_of_range = 0;
    int addr_hits [0:127];
    int beats_start, done_start, issue_start;
    logic bp_mode = 1'b0;
    logic ready_level = 1'b1;
    int   ready_phase = 0;

    always #5 clk = ~clk;

    qea_state_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_qbit_num   (i_qbit_num),
        .i_complete   (i_complete),
        .i_rd_start   (i_rd_start),
        .o_state_ena  (o_state_ena),
        .o_state_wea  (o_state_wea),
        .o_state_addra(o_state_addra),
        .i_state_dout (i_state_dout),
        .o_m_valid    (o_m_valid),
        .i_m_ready    (i_m_ready),
        .o_m_data     (o_m_data),
        .o_m_index    (o_m_index),
        .o_m_last     (o_m_last),
        .o_m_prob     (o_m_prob),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    // Two-cycle read RAM model: address registered, then output registered.
    always @(posedge clk) begin
        if (o_state_ena[0])
            rd_stage1 <= (o_state_addra < 16'd128) ? mem[o_state_addra[6:0]] : '0;
        rd_stage2 <= rd_stage1;
    end
    assign i_state_dout = rd_stage2;

    function automatic logic [63:0] amp_k(input int k);
        logic [31:0] re;
        re = 32'(k);
        return {re, ~re};
    endfunction

    function automatic logic [31:0] exp_prob(input logic [31:0] v);
        return v & PROB_MASK;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected, input int tol = 0);
        logic   bad;
        longint diff;
        num_checks++;
        if (tol == 0) begin
            bad = (actual !== expected);
        end else begin
            diff = longint'(actual[31:0]) - longint'(expected[31:0]);
            if (diff < 0) diff = -diff;
            bad = $isunknown(actual) || (diff > longint'(tol));
        end
        if (bad) begin
            num_failures++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic loadBasic();
        for (int r = 0; r < 128; r++) mem[r] = '0;
        mem[0] = {64'h4000_0000_0000_0000, 192'h0};
    endtask

    task automatic loadK();
        for (int r = 0; r < 128; r++)
            mem[r] = {amp_k(4*r), amp_k(4*r+1), amp_k(4*r+2), amp_k(4*r+3)};
    endtask

    task automatic applyStimulus(input int qbit, input int beats, input int pattern,
                                 input bit use_rd_start);
        beat_t b;
        for (int i = 0; i < beats; i++) begin
            b.index    = 18'(i);
            b.last     = (i == beats - 1);
            b.prob_tol = 0;
            if (pattern == PAT_BASIC) begin
                b.data = (i == 0) ? 64'h4000_0000_0000_0000 : 64'h0;
                b.prob = exp_prob((i == 0) ? 32'h4000_0000 : 32'h0);
            end else begin
                b.data = amp_k(i);
                b.prob = exp_prob(32'h0);
            end
            exp_q.push_back(b);
        end
        @(posedge clk); #1;
        i_qbit_num = 6'(qbit);
        if (use_rd_start) begin
            i_rd_start = 1'b1;
            @(posedge clk); #1;
            i_rd_start = 1'b0;
        end else begin
            i_complete = 1'b1;
        end
    endtask

    task automatic beginSweep();
        for (int a = 0; a < 128; a++) addr_hits[a] = 0;
        addr_out_of_range = 0;
        beats_start = beats_seen;
        done_start  = done_count;
        issue_start = issue_count;
    endtask

    task automatic waitSweep(input int max_cycles);
        for (int c = 0; c < max_cycles && done_count == done_start; c++) @(negedge clk);
        repeat (20) @(negedge clk);
    endtask

    task automatic endSweep(input string name, input int exp_beats, input int exp_rows);
        int bad_rows;
        bad_rows = addr_out_of_range;
        for (int a = 0; a < 128; a++)
            if (addr_hits[a] != ((a < exp_rows) ? 1 : 0)) bad_rows++;
        checkOutput({name, "_beats"}, 64'(beats_seen - beats_start), 64'(exp_beats));
        checkOutput({name, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        checkOutput({name, "_done_pulses"}, 64'(done_count - done_start), 64'd1);
        checkOutput({name, "_row_reads"}, 64'(issue_count - issue_start), 64'(exp_rows));
        checkOutput({name, "_addr_map_errors"}, 64'(bad_rows), 64'd0);
        checkOutput({name, "_busy_after"}, 64'(o_busy), 64'd0);
        exp_q.delete();
    endtask

    // Ready is driven just after the rising edge, either level or 1-high/2-low.
    initial begin : ready_drv
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                i_m_ready   = (ready_phase == 0);
                ready_phase = (ready_phase + 1) % 3;
            end else begin
                i_m_ready = ready_level;
            end
        end
    end

    initial begin : monitor
        beat_t e;
        logic  stall_prev;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            if (o_state_ena != 4'h0) begin
                issue_count++;
                if (o_state_addra < 16'd128) addr_hits[o_state_addra[6:0]]++;
                else addr_out_of_range++;
                checkOutput("ena_all_lanes", 64'(o_state_ena), 64'hF);
            end
            if (o_busy) begin
                busy_seen++;
                checkOutput("wea_zero", 64'(o_state_wea), 64'h0);
            end
            if (o_done) done_count++;
            if (stall_prev && exp_q.size() > 0) begin
                checkOutput("stall_valid", 64'(o_m_valid), 64'd1);
                checkOutput("stall_data", o_m_data, exp_q[0].data);
                checkOutput("stall_index", 64'(o_m_index), 64'(exp_q[0].index));
            end
            stall_prev = o_m_valid && !i_m_ready;
            if (o_m_valid && i_m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 64'(o_m_index), 64'h3_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("beat%0d_data", e.index), o_m_data, e.data);
                    checkOutput($sformatf("beat%0d_index", e.index), 64'(o_m_index), 64'(e.index));
                    checkOutput($sformatf("beat%0d_last", e.index), 64'(o_m_last), 64'(e.last));
                    checkOutput($sformatf("beat%0d_prob", e.index), 64'(o_m_prob), 64'(e.prob),
                                e.prob_tol);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        beat_t b;
        rst_n       = 1'b0;
        i_complete  = 1'b0;
        i_rd_start  = 1'b0;
        i_qbit_num  = 6'd0;
        ready_level = 1'b1;
        for (int r = 0; r < 128; r++) mem[r] = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_valid", 64'(o_m_valid), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_done", 64'(o_done), 64'd0);
        checkOutput("rst_err", 64'(o_err), 64'd0);
        checkOutput("rst_ena", 64'(o_state_ena), 64'd0);
        checkOutput("rst_addr", 64'(o_state_addra), 64'd0);
        checkOutput("rst_data", o_m_data, 64'd0);
        checkOutput("rst_index", 64'(o_m_index), 64'd0);
        checkOutput("rst_last", 64'(o_m_last), 64'd0);
        checkOutput("rst_prob", 64'(o_m_prob), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic drain, 9 qubits");
        loadBasic();
        beginSweep();
        applyStimulus(9, 512, PAT_BASIC, 1'b0);
        waitSweep(5000);
        endSweep("basic", 512, 128);
        @(posedge clk); #1;
        i_complete = 1'b0;

        $display("[TB] backpressure drain");
        loadK();
        bp_mode = 1'b1;
        beginSweep();
        applyStimulus(9, 512, PAT_K, 1'b1);
        waitSweep(10000);
        endSweep("backpressure", 512, 128);
        bp_mode = 1'b0;

        $display("[TB] small circuits");
        beginSweep();
        applyStimulus(2, 4, PAT_K, 1'b1);
        waitSweep(200);
        endSweep("qbit2", 4, 1);
        beginSweep();
        applyStimulus(1, 4, PAT_K, 1'b1);
        waitSweep(200);
        endSweep("qbit1", 4, 1);

        $display("[TB] range error");
        beginSweep();
        busy_seen = 0;
        @(posedge clk); #1;
        i_qbit_num = 6'd19;
        i_rd_start = 1'b1;
        @(posedge clk); #1;
        i_rd_start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("range_err", 64'(o_err), 64'd1);
        checkOutput("range_row_reads", 64'(issue_count - issue_start), 64'd0);
        checkOutput("range_busy_cycles", 64'(busy_seen), 64'd0);
        beginSweep();
        applyStimulus(2, 4, PAT_K, 1'b1);
        waitSweep(200);
        endSweep("after_err", 4, 1);
        checkOutput("err_sticky", 64'(o_err), 64'd1);

        $display("[TB] reset mid-sweep");
        beginSweep();
        applyStimulus(9, 512, PAT_K, 1'b0);
        for (int c = 0; c < 5000 && (beats_seen - beats_start) < 100; c++) @(negedge clk);
        #2;
        checkOutput("beat100_reached", 64'((beats_seen - beats_start) >= 100), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(o_m_valid), 64'd0);
        checkOutput("midrst_busy", 64'(o_busy), 64'd0);
        exp_q.delete();
        i_complete = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midrst_no_done", 64'(done_count - done_start), 64'd0);
        checkOutput("midrst_err_cleared", 64'(o_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] retrigger with stray complete edge");
        beginSweep();
        applyStimulus(9, 512, PAT_K, 1'b1);
        repeat (200) @(negedge clk);
        @(posedge clk); #1;
        i_complete = 1'b1;
        waitSweep(5000);
        endSweep("retrigger", 512, 128);
        @(posedge clk); #1;
        i_complete = 1'b0;

        $display("[TB] probability lanes");
        mem[0] = {32'h2D41_3CCD, 32'h2D41_3CCD, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                  32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'hC000_0000};
        b.data = {32'h2D41_3CCD, 32'h2D41_3CCD}; b.index = 18'd0; b.last = 1'b0;
        b.prob = exp_prob(32'h4000_0000); b.prob_tol = 2;
        exp_q.push_back(b);
        b.data = {32'h7FFF_FFFF, 32'h7FFF_FFFF}; b.index = 18'd1;
        b.prob = exp_prob(32'hFFFF_FFFF); b.prob_tol = 0;
        exp_q.push_back(b);
        b.data = {32'h8000_0000, 32'h0000_0000}; b.index = 18'd2;
        b.prob = exp_prob(32'hFFFF_FFFF);
        exp_q.push_back(b);
        b.data = {32'h0000_0000, 32'hC000_0000}; b.index = 18'd3; b.last = 1'b1;
        b.prob = exp_prob(32'h4000_0000);
        exp_q.push_back(b);
        beginSweep();
        applyStimulus(2, 0, PAT_K, 1'b1);
        waitSweep(200);
        endSweep("prob", 4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_failures);
        $finish;
    end

endmodule
